// File: rtl/mult_core.sv
// Unsigned iterative shift-add multiplier: one operand pair in flight, WIDTH
// iterations per product, truncated result plus an overflow flag.
module mult_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 last_iter;
  logic                 accept;

  // Any set bit above the result width means the product was truncated.
  function automatic logic trunc_ovf(input logic [2*WIDTH-1:0] prod);
    return |prod[2*WIDTH-1:WIDTH];
  endfunction

  assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign accept    = (state == IDLE) && in_valid;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: operand capture in IDLE, one shift-add step per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
      ovf    <= 1'b0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, in1};
      mplier <= in2;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last_iter) begin
        out <= acc_sum[WIDTH-1:0];
        ovf <= trunc_ovf(acc_sum);
      end
    end
  end

endmodule

// File: tb/tb_mult_core.sv
// Scoreboard bench for mult_core: the driver queues expected results on
// acceptance, an independent monitor checks each out_valid pulse.
module tb_mult_core;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             ovf;

  mult_core #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out(out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             ovf;
    int               acc_cyc;
  } exp_t;

  exp_t q[$];
  int   cycle    = 0;
  int   passed   = 0;
  int   total    = 0;
  int   last_acc = 0;
  bit   hold_chk = 0;
  logic [WIDTH-1:0] last_out;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitor: pops one expected entry per out_valid pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_chk) begin
        check("valid_one_cycle", {63'd0, out_valid}, 64'd0);
        check("out_hold", {32'd0, out}, {32'd0, last_out});
        hold_chk = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out", {32'd0, out}, {32'd0, e.out});
          check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
          check("latency", 64'(cycle - e.acc_cyc), 64'(WIDTH));
          last_out = out;
          hold_chk = 1;
        end
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] eo, input logic eovf,
                       input bit strict, input bit keep, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 64'd0, 64'd1);
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (strict) check("accept_spacing", 64'(cycle - last_acc), 64'(WIDTH + 2));
    last_acc = cycle;
    if (push) begin
      e.out = eo;
      e.ovf = eovf;
      e.acc_cyc = cycle;
      q.push_back(e);
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  logic [WIDTH-1:0] ra [10] = '{3, 31, 0, 1, 16, 7, 12, 31, 2, 19};
  logic [WIDTH-1:0] rb [10] = '{4, 30, 17, 1, 16, 9, 25, 1, 29, 23};
  logic [WIDTH-1:0] rp [10] = '{12, 930, 0, 1, 256, 63, 300, 31, 58, 437};

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    #3;
    check("rst_out", {32'd0, out}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd0, 32'd0, 32'd0, 1'b0, 0, 0, 1);
    issue(32'd31, 32'd31, 32'd961, 1'b0, 1, 0, 1);
    issue(32'd5, 32'd7, 32'd35, 1'b0, 1, 0, 1);
    // operands offered while BUSY must be held off until IDLE
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in1 = 32'd3;
    in2 = 32'd3;
    check("busy_in_ready", {63'd0, in_ready}, 64'd0);
    issue(32'd3, 32'd3, 32'd9, 1'b0, 1, 0, 1);
    issue(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1, 0, 1);
    issue(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 1, 0, 1);
    drain();

    // abort mid-multiply: nothing may come out afterwards
    issue(32'h0000_FFFF, 32'h0000_FFFF, 32'd0, 1'b0, 0, 0, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out", {32'd0, out}, 64'd0);
    check("abort_ovf", {63'd0, ovf}, 64'd0);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * WIDTH) @(negedge clk);
    check("abort_idle", {63'd0, in_ready}, 64'd1);
    check("abort_no_result", {32'd0, out}, 64'd0);

    for (int i = 0; i < 10; i++)
      issue(ra[i], rb[i], rp[i], 1'b0, (i > 0), 1, 1);
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
